// File: rtl/multicycle_ctrl.sv
// Multi-cycle MIPS main controller: sequences a shared ALU and a unified memory
// port through FETCH/DECODE/EXEC/MEM/WB, with a bounded mem_ready stall timeout.
module multicycle_ctrl #(
  parameter int MEM_TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_c,
  output logic       branch_ne,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_source,
  output logic       illegal_op,
  output logic       mem_fault,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2,  S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,  S_MEMWR  = 4'd5,  S_EXEC   = 4'd6,  S_RWB    = 4'd7,
    S_BRANCH = 4'd8,  S_JUMP   = 4'd9,  S_ADDIEX = 4'd10, S_ADDIWB = 4'd11,
    S_TRAP   = 4'd12
  } state_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;

  localparam int TO_LAST = (MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_c;
    logic       branch_ne;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       illegal_op;
    logic       mem_fault;
    logic [3:0] state;
  } ctrl_t;

  state_t     state_q, state_d;
  logic [7:0] wait_q;
  logic [5:0] op_q;
  logic       cause_mem_q;
  logic       mem_wait;
  logic       timeout;
  ctrl_t      c;

  // Memory-facing states stall while mem_ready is low.
  assign mem_wait = ((state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR))
                    && !mem_ready;
  assign timeout  = (MEM_TIMEOUT != 0) && mem_wait && (32'(wait_q) == TO_LAST);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:  if (mem_ready) state_d = S_DECODE;
                else if (timeout) state_d = S_TRAP;
      S_DECODE: begin
        case (opcode)
          OP_R:           state_d = S_EXEC;
          OP_LW, OP_SW:   state_d = S_MEMADR;
          OP_BEQ, OP_BNE: state_d = S_BRANCH;
          OP_ADDI:        state_d = S_ADDIEX;
          OP_J:           state_d = S_JUMP;
          default:        state_d = S_TRAP;
        endcase
      end
      S_MEMADR: state_d = (op_q == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  if (mem_ready) state_d = S_MEMWB;
                else if (timeout) state_d = S_TRAP;
      S_MEMWB:  state_d = S_FETCH;
      S_MEMWR:  if (mem_ready) state_d = S_FETCH;
                else if (timeout) state_d = S_TRAP;
      S_EXEC:   state_d = S_RWB;
      S_RWB:    state_d = S_FETCH;
      S_BRANCH: state_d = S_FETCH;
      S_JUMP:   state_d = S_FETCH;
      S_ADDIEX: state_d = S_ADDIWB;
      S_ADDIWB: state_d = S_FETCH;
      S_TRAP:   state_d = S_FETCH;
      default:  state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_FETCH;
      wait_q      <= '0;
      op_q        <= '0;
      cause_mem_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_d != state_q)
        wait_q <= '0;
      else if (mem_wait && (wait_q != 8'hFF))
        wait_q <= wait_q + 8'd1;
      if (state_q == S_DECODE)
        op_q <= opcode;
      // Only DECODE traps on opcode; every other entry into TRAP is a timeout.
      if ((state_d == S_TRAP) && (state_q != S_TRAP))
        cause_mem_q <= (state_q != S_DECODE);
    end
  end

  always_comb begin
    c = '0;
    case (state_q)
      S_FETCH: begin
        c.mem_read  = 1'b1;
        c.alu_src_b = 2'b01;
        c.ir_write  = mem_ready;
        c.pc_write  = mem_ready;
      end
      S_DECODE: c.alu_src_b = 2'b11;
      S_MEMADR: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'b10;
      end
      S_MEMRD: begin
        c.iord     = 1'b1;
        c.mem_read = 1'b1;
      end
      S_MEMWB: begin
        c.mem_to_reg = 1'b1;
        c.reg_write  = 1'b1;
      end
      S_MEMWR: begin
        c.iord      = 1'b1;
        c.mem_write = 1'b1;
      end
      S_EXEC: begin
        c.alu_src_a = 1'b1;
        c.alu_op    = 2'b10;
      end
      S_RWB: begin
        c.reg_dst   = 1'b1;
        c.reg_write = 1'b1;
      end
      S_BRANCH: begin
        c.alu_src_a  = 1'b1;
        c.alu_op     = 2'b01;
        c.pc_source  = 2'b01;
        c.pc_write_c = 1'b1;
        c.branch_ne  = (op_q == OP_BNE);
      end
      S_JUMP: begin
        c.pc_write  = 1'b1;
        c.pc_source = 2'b10;
      end
      S_ADDIEX: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'b10;
      end
      S_ADDIWB: c.reg_write = 1'b1;
      S_TRAP: begin
        c.illegal_op = !cause_mem_q;
        c.mem_fault  = cause_mem_q;
      end
      default: ;
    endcase
    c.state = state_q;
    // Reset is synchronous, so outputs are gated to keep strobes quiet during it.
    if (!rst_n) c = '0;
  end

  assign pc_write   = c.pc_write;
  assign pc_write_c = c.pc_write_c;
  assign branch_ne  = c.branch_ne;
  assign iord       = c.iord;
  assign mem_read   = c.mem_read;
  assign mem_write  = c.mem_write;
  assign ir_write   = c.ir_write;
  assign reg_dst    = c.reg_dst;
  assign mem_to_reg = c.mem_to_reg;
  assign reg_write  = c.reg_write;
  assign alu_src_a  = c.alu_src_a;
  assign alu_src_b  = c.alu_src_b;
  assign alu_op     = c.alu_op;
  assign pc_source  = c.pc_source;
  assign illegal_op = c.illegal_op;
  assign mem_fault  = c.mem_fault;
  assign state      = c.state;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: vector table, directed corner sequences, and a random
// run checked against an instruction-route reference model (timeouts 255 and 4).
module tb_multicycle_ctrl;

  typedef struct packed {
    logic pc_write, pc_write_c, branch_ne, iord, mem_read, mem_write, ir_write;
    logic reg_dst, mem_to_reg, reg_write, alu_src_a;
    logic [1:0] alu_src_b, alu_op, pc_source;
    logic illegal_op, mem_fault;
    logic [3:0] state;
  } out_t;

  typedef struct {
    logic r; logic [5:0] op; logic rdy;
    logic [3:0] st; logic rw, mtr, rd, mr, mw;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, mem_ready;
  logic [5:0] opcode;

  logic a_pc_write, a_pc_write_c, a_branch_ne, a_iord, a_mem_read, a_mem_write, a_ir_write;
  logic a_reg_dst, a_mem_to_reg, a_reg_write, a_alu_src_a, a_illegal_op, a_mem_fault;
  logic [1:0] a_alu_src_b, a_alu_op, a_pc_source;
  logic [3:0] a_state;
  logic b_pc_write, b_pc_write_c, b_branch_ne, b_iord, b_mem_read, b_mem_write, b_ir_write;
  logic b_reg_dst, b_mem_to_reg, b_reg_write, b_alu_src_a, b_illegal_op, b_mem_fault;
  logic [1:0] b_alu_src_b, b_alu_op, b_pc_source;
  logic [3:0] b_state;
  out_t oa, ob;

  assign oa = {a_pc_write, a_pc_write_c, a_branch_ne, a_iord, a_mem_read, a_mem_write, a_ir_write,
               a_reg_dst, a_mem_to_reg, a_reg_write, a_alu_src_a, a_alu_src_b, a_alu_op,
               a_pc_source, a_illegal_op, a_mem_fault, a_state};
  assign ob = {b_pc_write, b_pc_write_c, b_branch_ne, b_iord, b_mem_read, b_mem_write, b_ir_write,
               b_reg_dst, b_mem_to_reg, b_reg_write, b_alu_src_a, b_alu_src_b, b_alu_op,
               b_pc_source, b_illegal_op, b_mem_fault, b_state};

  multicycle_ctrl dut_a (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(a_pc_write), .pc_write_c(a_pc_write_c), .branch_ne(a_branch_ne), .iord(a_iord),
    .mem_read(a_mem_read), .mem_write(a_mem_write), .ir_write(a_ir_write), .reg_dst(a_reg_dst),
    .mem_to_reg(a_mem_to_reg), .reg_write(a_reg_write), .alu_src_a(a_alu_src_a),
    .alu_src_b(a_alu_src_b), .alu_op(a_alu_op), .pc_source(a_pc_source),
    .illegal_op(a_illegal_op), .mem_fault(a_mem_fault), .state(a_state));

  multicycle_ctrl #(.MEM_TIMEOUT(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(b_pc_write), .pc_write_c(b_pc_write_c), .branch_ne(b_branch_ne), .iord(b_iord),
    .mem_read(b_mem_read), .mem_write(b_mem_write), .ir_write(b_ir_write), .reg_dst(b_reg_dst),
    .mem_to_reg(b_mem_to_reg), .reg_write(b_reg_write), .alu_src_a(b_alu_src_a),
    .alu_src_b(b_alu_src_b), .alu_op(b_alu_op), .pc_source(b_pc_source),
    .illegal_op(b_illegal_op), .mem_fault(b_mem_fault), .state(b_state));

  int n_chk = 0, n_fail = 0;

  // Reference model: each instruction is a route of phases; memory phases wait.
  out_t       tab[13];
  int         m_to[2] = '{255, 4};
  int         m_cur[2], m_pos[2], m_stalls[2];
  bit         m_mem[2];
  logic [5:0] m_op[2];

  function automatic int route_at(input logic [5:0] op, input int p);
    int r[6];
    case (op)
      6'h00:       r = '{0, 1, 6, 7, -1, -1};
      6'h23:       r = '{0, 1, 2, 3, 4, -1};
      6'h2B:       r = '{0, 1, 2, 5, -1, -1};
      6'h04, 6'h05: r = '{0, 1, 8, -1, -1, -1};
      6'h08:       r = '{0, 1, 10, 11, -1, -1};
      6'h02:       r = '{0, 1, 9, -1, -1, -1};
      default:     r = '{0, 1, 12, -1, -1, -1};
    endcase
    return r[p];
  endfunction

  task automatic model_step(input int k, input logic r, input logic [5:0] op, input logic rdy);
    int nxt;
    if (!r) begin
      m_cur[k] = 0; m_pos[k] = 0; m_stalls[k] = 0; m_op[k] = '0;
      return;
    end
    if (m_cur[k] == 12) begin
      m_cur[k] = 0; m_pos[k] = 0; m_stalls[k] = 0;
      return;
    end
    if (m_cur[k] == 1) m_op[k] = op;
    if ((m_cur[k] == 0 || m_cur[k] == 3 || m_cur[k] == 5) && !rdy) begin
      m_stalls[k]++;
      if (m_to[k] != 0 && m_stalls[k] == m_to[k]) begin
        m_cur[k] = 12; m_mem[k] = 1'b1; m_stalls[k] = 0;
      end
      return;
    end
    m_stalls[k] = 0;
    m_pos[k]++;
    nxt = route_at(m_op[k], m_pos[k]);
    if (nxt < 0) begin m_pos[k] = 0; nxt = 0; end
    if (nxt == 12) m_mem[k] = 1'b0;
    m_cur[k] = nxt;
  endtask

  function automatic out_t exp_out(input int k, input logic r, input logic rdy);
    out_t o;
    if (!r) return '0;
    o = tab[m_cur[k]];
    if (m_cur[k] == 0) begin o.ir_write = rdy; o.pc_write = rdy; end
    if (m_cur[k] == 8) o.branch_ne = (m_op[k] == 6'h05);
    if (m_cur[k] == 12) begin o.illegal_op = !m_mem[k]; o.mem_fault = m_mem[k]; end
    o.state = 4'(m_cur[k]);
    return o;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic [5:0] op, input logic rdy);
    @(negedge clk);
    rst_n = r; opcode = op; mem_ready = rdy;
    #1;
    check("model_a", 32'(oa), 32'(exp_out(0, r, rdy)));
    check("model_b", 32'(ob), 32'(exp_out(1, r, rdy)));
  endtask

  task automatic tick(input logic r, input logic [5:0] op, input logic rdy);
    @(posedge clk);
    model_step(0, r, op, rdy);
    model_step(1, r, op, rdy);
  endtask

  task automatic step(input logic r, input logic [5:0] op, input logic rdy);
    drive(r, op, rdy);
    tick(r, op, rdy);
  endtask

  vec_t vecs[14];
  int   burst;

  initial begin
    for (int i = 0; i < 13; i++) tab[i] = '0;
    tab[0].mem_read = 1'b1;  tab[0].alu_src_b = 2'b01;
    tab[1].alu_src_b = 2'b11;
    tab[2].alu_src_a = 1'b1; tab[2].alu_src_b = 2'b10;
    tab[3].iord = 1'b1;      tab[3].mem_read = 1'b1;
    tab[4].mem_to_reg = 1'b1; tab[4].reg_write = 1'b1;
    tab[5].iord = 1'b1;      tab[5].mem_write = 1'b1;
    tab[6].alu_src_a = 1'b1; tab[6].alu_op = 2'b10;
    tab[7].reg_dst = 1'b1;   tab[7].reg_write = 1'b1;
    tab[8].alu_src_a = 1'b1; tab[8].alu_op = 2'b01; tab[8].pc_source = 2'b01; tab[8].pc_write_c = 1'b1;
    tab[9].pc_write = 1'b1;  tab[9].pc_source = 2'b10;
    tab[10].alu_src_a = 1'b1; tab[10].alu_src_b = 2'b10;
    tab[11].reg_write = 1'b1;
    for (int k = 0; k < 2; k++) begin
      m_cur[k] = 0; m_pos[k] = 0; m_stalls[k] = 0; m_mem[k] = 1'b0; m_op[k] = '0;
    end
    rst_n = 1'b0; opcode = '0; mem_ready = 1'b0;

    // {rst_n, opcode, mem_ready} -> {state, reg_write, mem_to_reg, reg_dst, mem_read, mem_write}
    vecs[0]  = '{1'b0, 6'h00, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 6'h00, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[2]  = '{1'b1, 6'h00, 1'b1, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, 6'h00, 1'b1, 4'd6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{1'b1, 6'h00, 1'b1, 4'd7, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[5]  = '{1'b1, 6'h23, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[6]  = '{1'b1, 6'h23, 1'b1, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{1'b1, 6'h23, 1'b1, 4'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{1'b1, 6'h23, 1'b0, 4'd3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[9]  = '{1'b1, 6'h23, 1'b0, 4'd3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[10] = '{1'b1, 6'h23, 1'b0, 4'd3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[11] = '{1'b1, 6'h23, 1'b1, 4'd3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[12] = '{1'b1, 6'h23, 1'b1, 4'd4, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[13] = '{1'b1, 6'h23, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

    for (int i = 0; i < 14; i++) begin
      drive(vecs[i].r, vecs[i].op, vecs[i].rdy);
      check($sformatf("vec%0d_state", i), 32'(a_state), 32'(vecs[i].st));
      check($sformatf("vec%0d_reg_write", i), 32'(a_reg_write), 32'(vecs[i].rw));
      check($sformatf("vec%0d_mem_to_reg", i), 32'(a_mem_to_reg), 32'(vecs[i].mtr));
      check($sformatf("vec%0d_reg_dst", i), 32'(a_reg_dst), 32'(vecs[i].rd));
      check($sformatf("vec%0d_mem_read", i), 32'(a_mem_read), 32'(vecs[i].mr));
      check($sformatf("vec%0d_mem_write", i), 32'(a_mem_write), 32'(vecs[i].mw));
      tick(vecs[i].r, vecs[i].op, vecs[i].rdy);
    end

    // bne then beq
    step(1'b1, 6'h05, 1'b1);
    step(1'b1, 6'h05, 1'b1);
    drive(1'b1, 6'h05, 1'b1);
    check("bne_state", 32'(a_state), 32'd8);
    check("bne_pc_write_c", 32'(a_pc_write_c), 32'd1);
    check("bne_branch_ne", 32'(a_branch_ne), 32'd1);
    check("bne_alu_op", 32'(a_alu_op), 32'd1);
    tick(1'b1, 6'h05, 1'b1);
    step(1'b1, 6'h04, 1'b1);
    step(1'b1, 6'h04, 1'b1);
    drive(1'b1, 6'h04, 1'b1);
    check("beq_pc_write_c", 32'(a_pc_write_c), 32'd1);
    check("beq_branch_ne", 32'(a_branch_ne), 32'd0);
    tick(1'b1, 6'h04, 1'b1);

    // illegal opcode
    step(1'b1, 6'h3F, 1'b1);
    step(1'b1, 6'h3F, 1'b1);
    drive(1'b1, 6'h3F, 1'b1);
    check("ill_state", 32'(a_state), 32'd12);
    check("ill_illegal_op", 32'(a_illegal_op), 32'd1);
    check("ill_mem_fault", 32'(a_mem_fault), 32'd0);
    check("ill_reg_write", 32'(a_reg_write), 32'd0);
    check("ill_mem_write", 32'(a_mem_write), 32'd0);
    tick(1'b1, 6'h3F, 1'b1);
    drive(1'b1, 6'h00, 1'b0);
    check("ill_after_state", 32'(a_state), 32'd0);
    check("ill_after_pulse", 32'(a_illegal_op), 32'd0);
    tick(1'b1, 6'h00, 1'b0);

    // sw stalled forever: timeout-4 instance traps, default instance keeps waiting
    step(1'b1, 6'h2B, 1'b1);
    step(1'b1, 6'h2B, 1'b1);
    step(1'b1, 6'h2B, 1'b1);
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 6'h2B, 1'b0);
      check($sformatf("to_memwr%0d_state", i), 32'(b_state), 32'd5);
      check($sformatf("to_memwr%0d_mem_write", i), 32'(b_mem_write), 32'd1);
      tick(1'b1, 6'h2B, 1'b0);
    end
    drive(1'b1, 6'h2B, 1'b0);
    check("to_trap_state", 32'(b_state), 32'd12);
    check("to_mem_fault", 32'(b_mem_fault), 32'd1);
    check("to_illegal_op", 32'(b_illegal_op), 32'd0);
    check("to_mem_write", 32'(b_mem_write), 32'd0);
    check("to_default_waits", 32'(a_state), 32'd5);
    tick(1'b1, 6'h2B, 1'b0);
    drive(1'b1, 6'h2B, 1'b0);
    check("to_back_fetch", 32'(b_state), 32'd0);
    check("to_default_mem_write", 32'(a_mem_write), 32'd1);
    tick(1'b1, 6'h2B, 1'b0);

    // reset in the middle of the default instance's MEMWR stall
    drive(1'b0, 6'h2B, 1'b0);
    check("rst_outputs_zero", 32'(oa), 32'd0);
    tick(1'b0, 6'h2B, 1'b0);
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 6'h2B, 1'b0);
      check($sformatf("rst_rel%0d_state", i), 32'(a_state), 32'd0);
      check($sformatf("rst_rel%0d_mem_write", i), 32'(a_mem_write), 32'd0);
      tick(1'b1, 6'h2B, 1'b0);
    end

    // random run against the model, including one stall long enough for the 255 timeout
    burst = 0;
    for (int i = 0; i < 3000; i++) begin
      logic       r, rdy;
      logic [5:0] op;
      if (i == 1500) burst = 300;
      r = (burst > 0) || ($urandom_range(0, 199) != 0);
      case ($urandom_range(0, 7))
        0: op = 6'h00;
        1: op = 6'h23;
        2: op = 6'h2B;
        3: op = 6'h04;
        4: op = 6'h05;
        5: op = 6'h08;
        6: op = 6'h02;
        default: op = 6'($urandom);
      endcase
      if (burst > 0) begin
        rdy = 1'b0;
        burst--;
      end else begin
        rdy = ($urandom_range(0, 9) < 7);
        if ($urandom_range(0, 49) == 0) burst = $urandom_range(3, 8);
      end
      step(r, op, rdy);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
